pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Hazard and sequencing controller for the five-stage RV64 pipeline. It is the single source of the en/stall/flush inputs of the four pipe registers and the PC. It also drives the forwarding selects for the ID-stage branch comparator and the EX-stage ALU operands. It detects RAW and load-use hazards, kills wrong-path fetches on taken branches, and freezes the whole pipeline while data memory is not ready. It sits beside the data path and consumes only register indices and control bits already present in the pipe registers.

## Interface
- MEM_TIMEOUT, 64: maximum consecutive not-ready cycles before mem_err is raised
- CNT_WIDTH, 32: width of the performance counters
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; asynchronous, active-high
- id_rs1, id_rs2  in  5  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  instruction in ID reads rs1/rs2
- id_branch  in  1  instruction in ID is a branch or jalr (operands compared in ID)
- id_branch_taken  in  1  raw taken flag from branch_cal_unit
- ex_rd, mem_rd, wb_rd  in  5  destination register per stage
- ex_reg_we, mem_reg_we, wb_reg_we  in  1  register write enable per stage
- ex_mem_re, mem_mem_re, mem_mem_we  in  1  load in EX; load/store in MEM
- dmem_ready  in  1  data memory completes the MEM-stage access this cycle
- branch_commit  out  1  id_branch_taken qualified by no stall/freeze; drives pc redirect
- pc_stall  out  1  hold PC
- if_id_en, if_id_stall, if_id_flush  out  1  IF/ID register control
- id_ex_en, id_ex_stall, id_ex_flush  out  1  ID/EX register control
- ex_mem_en, ex_mem_stall, ex_mem_flush  out  1  EX/MEM register control
- mem_wb_en, mem_wb_stall, mem_wb_flush  out  1  MEM/WB register control
- id_fwd_a_sel, id_fwd_b_sel  out  2  ID operand select: 0 reg_file, 1 mem_alu_res, 2 WB write data
- ex_fwd_a_sel, ex_fwd_b_sel  out  2  EX operand select: 0 pipe value, 1 mem_alu_res, 2 WB write data
- mem_err  out  1  sticky: memory wait exceeded MEM_TIMEOUT
- stall_cnt, flush_cnt  out  CNT_WIDTH  bubble cycles inserted / wrong-path instructions killed

## Operation
- Register matching: a stage is a producer for rs iff reg_we=1, rd≠0, and rd==rs. EX has priority over MEM, and MEM has priority over WB.
- The FSM has three states.
  - RUN: normal flow.
  - MEM_WAIT: entered when (mem_mem_re|mem_mem_we) & ~dmem_ready. Exited to RUN on the cycle dmem_ready=1.
  - ERR: entered when the wait counter reaches MEM_TIMEOUT. Exited only by rst.
- Freeze (MEM access & ~dmem_ready, or state ERR):
  - all *_en=0, all *_stall=1, all *_flush=0, pc_stall=1, branch_commit=0.
  - Freeze has top priority.
- Load-use stall: a used rs matches ex_rd with ex_mem_re. Also stalls when id_branch and a used rs matches ex_rd (any producer), or matches mem_rd with mem_mem_re.
  - Response: pc_stall=1, if_id_stall=1, id_ex_flush=1 (bubble), branch_commit=0. Later stages advance.
- Branch flush: branch_commit=id_branch_taken & ~stall & ~freeze. While branch_commit=1, if_id_flush=1 (one wrong-path instruction killed).
- Forwarding: ex_fwd_*_sel picks MEM (1) then WB (2) against ex_rs1/ex_rs2, as latched internally from id_rs* on ID/EX advance. id_fwd_*_sel picks MEM then WB against id_rs*. A MEM load is never a forwarding source.
- Counters:
  - stall_cnt increments on every load-use or freeze cycle.
  - flush_cnt increments on every branch_commit.
  - Both wrap modulo 2^CNT_WIDTH.
- Wait counter: clears on RUN and counts MEM_WAIT cycles. mem_err sets when it equals MEM_TIMEOUT.

## Timing
- All control and select outputs are combinational from inputs and the registered state. There is no added latency.
- Load-use costs exactly 1 bubble. A branch on the result of the preceding ALU instruction costs 1 bubble. A branch on the result of the preceding load costs 2 bubbles.
- A taken branch costs 1 killed slot.
- dmem_ready=1 in the first MEM cycle gives zero freeze cycles. N not-ready cycles give N frozen cycles.
- While rst=1 or after async reset assertion:
  - state=RUN, counters=0, mem_err=0, ex_rs latches=0.
  - all *_en=0, stall=0, flush=0, selects=0, branch_commit=0.
- Reset mid-MEM_WAIT returns to RUN immediately. There is no pending completion.
- Simultaneous load-use and freeze: freeze only, and no bubble is inserted until the freeze is released.

## Configuration
- PIPE_CTRL_FORWARD_EN defined: forwarding as above.
- Not defined:
  - all *_fwd_*_sel tied to 0.
  - any used rs matching a producer in EX, MEM or WB stalls, with the same response as load-use.
  - reg_file has no write bypass, so WB matches also stall.

## Structure
- Add the following to include/common.vh:
  - FWD_SEL_REG/MEM/WB encodings
  - PCTRL_RUN/MEM_WAIT/ERR state encodings
  - the PIPE_CTRL_FORWARD_EN default
- One sub-module, hazard_fwd_sel: combinational producer match and priority for one rs. It returns the sel value and a hit-in-EX / hit-load flag, and is instantiated four times.

## Test plan
- ld x5 then add x6,x5,x1 → one cycle with pc_stall=1, id_ex_flush=1; then ex_fwd_a_sel=2; stall_cnt=1.
- add x5 then sub x7,x5,x5 → no stall; ex_fwd_a_sel=ex_fwd_b_sel=1.
- addi x3 then beq x3,x0 taken → 1 bubble, then branch_commit=1, if_id_flush=1 for one cycle; flush_cnt=1.
- sd with dmem_ready low 3 cycles → 3 frozen cycles (all en=0, state MEM_WAIT); RUN on ready.
- dmem_ready held low 64 cycles → mem_err=1, state ERR; rst clears all outputs and counters.
- Without PIPE_CTRL_FORWARD_EN, add x5 then add x6,x5,x0 → 3 stall cycles, selects stay 0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings and helpers for the pipeline hazard/sequencing controller.
// Forwarding paths are compiled in only when PIPE_CTRL_FORWARD_EN is defined.
package pipeline_ctrl_pkg;
   typedef enum logic [1:0] {
      PCTRL_RUN      = 2'd0,
      PCTRL_MEM_WAIT = 2'd1,
      PCTRL_ERR      = 2'd2
   } pctrl_state_t;

   localparam logic [1:0] FWD_SEL_REG = 2'd0;
   localparam logic [1:0] FWD_SEL_MEM = 2'd1;
   localparam logic [1:0] FWD_SEL_WB  = 2'd2;

   // x0 is hardwired to zero, so a write to it never creates a dependency.
   function automatic logic reg_match(input logic we, input logic [4:0] rd, input logic [4:0] rs);
      return we && (rd != 5'd0) && (rd == rs);
   endfunction
endpackage

// File: rtl/pipeline_ctrl_if.sv
// Control/status bundle between the RV64 data path (master) and pipeline_ctrl (slave).
interface pipeline_ctrl_if #(parameter int CNT_WIDTH = 32);
   logic [4:0]           id_rs1, id_rs2;
   logic                 id_use_rs1, id_use_rs2, id_branch, id_branch_taken;
   logic [4:0]           ex_rd, mem_rd, wb_rd;
   logic                 ex_reg_we, mem_reg_we, wb_reg_we;
   logic                 ex_mem_re, mem_mem_re, mem_mem_we, dmem_ready;
   logic                 branch_commit, pc_stall;
   logic                 if_id_en, if_id_stall, if_id_flush;
   logic                 id_ex_en, id_ex_stall, id_ex_flush;
   logic                 ex_mem_en, ex_mem_stall, ex_mem_flush;
   logic                 mem_wb_en, mem_wb_stall, mem_wb_flush;
   logic [1:0]           id_fwd_a_sel, id_fwd_b_sel, ex_fwd_a_sel, ex_fwd_b_sel;
   logic                 mem_err;
   logic [CNT_WIDTH-1:0] stall_cnt, flush_cnt;

   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_branch, id_branch_taken,
             ex_rd, mem_rd, wb_rd, ex_reg_we, mem_reg_we, wb_reg_we,
             ex_mem_re, mem_mem_re, mem_mem_we, dmem_ready,
      input  branch_commit, pc_stall, if_id_en, if_id_stall, if_id_flush,
             id_ex_en, id_ex_stall, id_ex_flush, ex_mem_en, ex_mem_stall, ex_mem_flush,
             mem_wb_en, mem_wb_stall, mem_wb_flush,
             id_fwd_a_sel, id_fwd_b_sel, ex_fwd_a_sel, ex_fwd_b_sel,
             mem_err, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_branch, id_branch_taken,
             ex_rd, mem_rd, wb_rd, ex_reg_we, mem_reg_we, wb_reg_we,
             ex_mem_re, mem_mem_re, mem_mem_we, dmem_ready,
      output branch_commit, pc_stall, if_id_en, if_id_stall, if_id_flush,
             id_ex_en, id_ex_stall, id_ex_flush, ex_mem_en, ex_mem_stall, ex_mem_flush,
             mem_wb_en, mem_wb_stall, mem_wb_flush,
             id_fwd_a_sel, id_fwd_b_sel, ex_fwd_a_sel, ex_fwd_b_sel,
             mem_err, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipeline_ctrl_hazard_fwd_sel.sv
// Producer match for one source register: EX > MEM > WB priority, forwarding
// select plus hazard flags used by the stall logic.
module hazard_fwd_sel
   import pipeline_ctrl_pkg::*;
(
   input  logic [4:0] i_rs,
   input  logic       i_use,
   input  logic [4:0] i_ex_rd,
   input  logic       i_ex_we,
   input  logic       i_ex_load,
   input  logic [4:0] i_mem_rd,
   input  logic       i_mem_we,
   input  logic       i_mem_load,
   input  logic [4:0] i_wb_rd,
   input  logic       i_wb_we,
   output logic [1:0] o_sel,
   output logic       o_hit_ex,
   output logic       o_hit_ex_load,
   output logic       o_hit_mem_load,
   output logic       o_hit_any
);
   logic w_ex, w_mem, w_wb;

   assign w_ex  = i_use && reg_match(i_ex_we,  i_ex_rd,  i_rs);
   assign w_mem = i_use && reg_match(i_mem_we, i_mem_rd, i_rs);
   assign w_wb  = i_use && reg_match(i_wb_we,  i_wb_rd,  i_rs);

   assign o_hit_ex       = w_ex;
   assign o_hit_ex_load  = w_ex & i_ex_load;
   assign o_hit_mem_load = ~w_ex & w_mem & i_mem_load;
   assign o_hit_any      = w_ex | w_mem | w_wb;

   // A load in MEM has no data yet, and an older WB value would be stale.
   always_comb begin
      o_sel = FWD_SEL_REG;
      if (w_ex)
         o_sel = FWD_SEL_REG;
      else if (w_mem)
         o_sel = i_mem_load ? FWD_SEL_REG : FWD_SEL_MEM;
      else if (w_wb)
         o_sel = FWD_SEL_WB;
   end
endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the five-stage RV64 pipeline.
// Define PIPE_CTRL_FORWARD_EN to enable operand forwarding; otherwise every RAW dependency stalls.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_WIDTH   = 32
) (
   input  logic             clk,
   input  logic             rst,
   pipeline_ctrl_if.slave   bus
);
   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   pctrl_state_t         r_state;
   logic [WAIT_W-1:0]    r_wait_cnt;
   logic                 r_mem_err;
   logic [CNT_WIDTH-1:0] r_stall_cnt, r_flush_cnt;
   logic [4:0]           r_ex_rs1, r_ex_rs2;

   logic [3:0][4:0] w_rs;
   logic [3:0]      w_use;
   logic [3:0][1:0] w_sel;
   logic [3:0]      w_hit_ex, w_hit_ex_load, w_hit_mem_load, w_hit_any;
   logic            w_mem_acc, w_freeze, w_hazard;
   logic [WAIT_W-1:0] w_wait_inc;
   logic            w_pc_stall, w_branch_commit;
   logic            w_if_id_en, w_if_id_stall, w_if_id_flush;
   logic            w_id_ex_en, w_id_ex_stall, w_id_ex_flush;
   logic            w_ex_mem_en, w_ex_mem_stall, w_mem_wb_en, w_mem_wb_stall;
   logic            w_unused;

   // Slots 0/1 check the ID operands; slots 2/3 check the latched EX operands.
   assign w_rs  = {r_ex_rs2, r_ex_rs1, bus.id_rs2, bus.id_rs1};
   assign w_use = {1'b1, 1'b1, bus.id_use_rs2, bus.id_use_rs1};

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_sel
         hazard_fwd_sel u_sel (
            .i_rs           (w_rs[gi]),
            .i_use          (w_use[gi]),
            .i_ex_rd        (bus.ex_rd),
            .i_ex_we        ((gi < 2) ? bus.ex_reg_we : 1'b0),
            .i_ex_load      (bus.ex_mem_re),
            .i_mem_rd       (bus.mem_rd),
            .i_mem_we       (bus.mem_reg_we),
            .i_mem_load     (bus.mem_mem_re),
            .i_wb_rd        (bus.wb_rd),
            .i_wb_we        (bus.wb_reg_we),
            .o_sel          (w_sel[gi]),
            .o_hit_ex       (w_hit_ex[gi]),
            .o_hit_ex_load  (w_hit_ex_load[gi]),
            .o_hit_mem_load (w_hit_mem_load[gi]),
            .o_hit_any      (w_hit_any[gi])
         );
      end
   endgenerate

   assign w_mem_acc  = bus.mem_mem_re | bus.mem_mem_we;
   assign w_freeze   = (w_mem_acc & ~bus.dmem_ready) | (r_state == PCTRL_ERR);
   assign w_wait_inc = r_wait_cnt + WAIT_W'(1);

`ifdef PIPE_CTRL_FORWARD_EN
   // Branches compare in ID, so they also wait for ALU results still in EX and loads in MEM.
   assign w_hazard = (|w_hit_ex_load[1:0]) |
                     (bus.id_branch & ((|w_hit_ex[1:0]) | (|w_hit_mem_load[1:0])));
   assign bus.id_fwd_a_sel = rst ? FWD_SEL_REG : w_sel[0];
   assign bus.id_fwd_b_sel = rst ? FWD_SEL_REG : w_sel[1];
   assign bus.ex_fwd_a_sel = rst ? FWD_SEL_REG : w_sel[2];
   assign bus.ex_fwd_b_sel = rst ? FWD_SEL_REG : w_sel[3];
`else
   assign w_hazard = |w_hit_any[1:0];
   assign bus.id_fwd_a_sel = FWD_SEL_REG;
   assign bus.id_fwd_b_sel = FWD_SEL_REG;
   assign bus.ex_fwd_a_sel = FWD_SEL_REG;
   assign bus.ex_fwd_b_sel = FWD_SEL_REG;
`endif

   assign w_unused = ^{w_sel, w_hit_ex, w_hit_ex_load, w_hit_mem_load, w_hit_any, bus.id_branch};

   always_comb begin
      w_pc_stall = 1'b0;  w_branch_commit = 1'b0;
      w_if_id_en = 1'b0;  w_if_id_stall = 1'b0;  w_if_id_flush = 1'b0;
      w_id_ex_en = 1'b0;  w_id_ex_stall = 1'b0;  w_id_ex_flush = 1'b0;
      w_ex_mem_en = 1'b0; w_ex_mem_stall = 1'b0;
      w_mem_wb_en = 1'b0; w_mem_wb_stall = 1'b0;
      if (!rst) begin
         if (w_freeze) begin
            w_pc_stall = 1'b1;     w_if_id_stall = 1'b1;  w_id_ex_stall = 1'b1;
            w_ex_mem_stall = 1'b1; w_mem_wb_stall = 1'b1;
         end else begin
            w_if_id_en = 1'b1; w_id_ex_en = 1'b1; w_ex_mem_en = 1'b1; w_mem_wb_en = 1'b1;
            if (w_hazard) begin
               w_pc_stall = 1'b1; w_if_id_en = 1'b0; w_if_id_stall = 1'b1; w_id_ex_flush = 1'b1;
            end else begin
               w_branch_commit = bus.id_branch_taken;
               w_if_id_flush   = bus.id_branch_taken;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= PCTRL_RUN;
         r_wait_cnt  <= '0;
         r_mem_err   <= 1'b0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
         r_ex_rs1    <= '0;
         r_ex_rs2    <= '0;
      end else begin
         if (w_hazard | w_freeze)
            r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
         if (w_branch_commit)
            r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
         if (w_id_ex_en) begin
            r_ex_rs1 <= w_id_ex_flush ? 5'd0 : bus.id_rs1;
            r_ex_rs2 <= w_id_ex_flush ? 5'd0 : bus.id_rs2;
         end
         case (r_state)
            PCTRL_RUN, PCTRL_MEM_WAIT: begin
               if (w_mem_acc & ~bus.dmem_ready) begin
                  r_wait_cnt <= w_wait_inc;
                  if (w_wait_inc == WAIT_W'(MEM_TIMEOUT)) begin
                     r_state   <= PCTRL_ERR;
                     r_mem_err <= 1'b1;
                  end else begin
                     r_state <= PCTRL_MEM_WAIT;
                  end
               end else begin
                  r_state    <= PCTRL_RUN;
                  r_wait_cnt <= '0;
               end
            end
            PCTRL_ERR: r_state <= PCTRL_ERR;
            default:   r_state <= PCTRL_RUN;
         endcase
      end
   end

   assign bus.branch_commit = w_branch_commit;
   assign bus.pc_stall      = w_pc_stall;
   assign bus.if_id_en      = w_if_id_en;
   assign bus.if_id_stall   = w_if_id_stall;
   assign bus.if_id_flush   = w_if_id_flush;
   assign bus.id_ex_en      = w_id_ex_en;
   assign bus.id_ex_stall   = w_id_ex_stall;
   assign bus.id_ex_flush   = w_id_ex_flush;
   assign bus.ex_mem_en     = w_ex_mem_en;
   assign bus.ex_mem_stall  = w_ex_mem_stall;
   assign bus.ex_mem_flush  = 1'b0;
   assign bus.mem_wb_en     = w_mem_wb_en;
   assign bus.mem_wb_stall  = w_mem_wb_stall;
   assign bus.mem_wb_flush  = 1'b0;
   assign bus.mem_err       = r_mem_err;
   assign bus.stall_cnt     = r_stall_cnt;
   assign bus.flush_cnt     = r_flush_cnt;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl; forwarding-specific steps follow PIPE_CTRL_FORWARD_EN.
module tb_pipeline_ctrl;
   logic clk;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   pipeline_ctrl_if #(.CNT_WIDTH(32)) bus ();

   pipeline_ctrl #(.MEM_TIMEOUT(64), .CNT_WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {pc_stall, if_id en/stall/flush, id_ex en/stall/flush, ex_mem ..., mem_wb ..., branch_commit}
   localparam logic [13:0] C_ZERO   = 14'b0_000_000_000_000_0;
   localparam logic [13:0] C_RUN    = 14'b0_100_100_100_100_0;
   localparam logic [13:0] C_COMMIT = 14'b0_101_100_100_100_1;
   localparam logic [13:0] C_STALL  = 14'b1_010_101_100_100_0;
   localparam logic [13:0] C_FREEZE = 14'b1_010_010_010_010_0;

   function automatic logic [13:0] ctl();
      return {bus.pc_stall, bus.if_id_en, bus.if_id_stall, bus.if_id_flush,
              bus.id_ex_en, bus.id_ex_stall, bus.id_ex_flush,
              bus.ex_mem_en, bus.ex_mem_stall, bus.ex_mem_flush,
              bus.mem_wb_en, bus.mem_wb_stall, bus.mem_wb_flush, bus.branch_commit};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ctl(input string tag, input logic [13:0] exp);
      $display("[%0t] %s ctl=%b", $time, tag, ctl());
      chk(tag, 64'(ctl()), 64'(exp));
   endtask

   task automatic idle();
      bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0; bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
      bus.id_branch = 1'b0; bus.id_branch_taken = 1'b0;
      bus.ex_rd = 5'd0; bus.mem_rd = 5'd0; bus.wb_rd = 5'd0;
      bus.ex_reg_we = 1'b0; bus.mem_reg_we = 1'b0; bus.wb_reg_we = 1'b0;
      bus.ex_mem_re = 1'b0; bus.mem_mem_re = 1'b0; bus.mem_mem_we = 1'b0;
      bus.dmem_ready = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      // Hazard and branch inputs active while in reset: outputs must stay quiet.
      bus.id_rs1 = 5'd5; bus.id_use_rs1 = 1'b1; bus.ex_rd = 5'd5; bus.ex_reg_we = 1'b1;
      bus.ex_mem_re = 1'b1; bus.id_branch_taken = 1'b1;
      bus.mem_rd = 5'd5; bus.mem_reg_we = 1'b1; bus.id_rs2 = 5'd5; bus.id_use_rs2 = 1'b1;
      #2;
      chk_ctl("reset_ctl", C_ZERO);
      chk("reset_stall_cnt", 64'(bus.stall_cnt), 64'd0);
      chk("reset_flush_cnt", 64'(bus.flush_cnt), 64'd0);
      chk("reset_mem_err", 64'(bus.mem_err), 64'd0);
      chk("reset_id_fwd_b", 64'(bus.id_fwd_b_sel), 64'd0);
      tick();
      chk_ctl("reset_ctl_after_edge", C_ZERO);
      rst = 1'b0;
      idle();

      // Independent instructions: no hazard.
      bus.id_rs1 = 5'd1; bus.id_rs2 = 5'd2; bus.id_use_rs1 = 1'b1; bus.id_use_rs2 = 1'b1;
      bus.ex_rd = 5'd3; bus.ex_reg_we = 1'b1; bus.mem_rd = 5'd4; bus.mem_reg_we = 1'b1;
      bus.wb_rd = 5'd7; bus.wb_reg_we = 1'b1;
      #1 chk_ctl("no_hazard", C_RUN);
      chk("no_hazard_id_fwd_a", 64'(bus.id_fwd_a_sel), 64'd0);
      tick();
      chk("no_hazard_stall_cnt", 64'(bus.stall_cnt), 64'd0);

      // x0 never creates a dependency, even as a load destination.
      idle();
      bus.id_rs1 = 5'd0; bus.id_use_rs1 = 1'b1; bus.ex_rd = 5'd0; bus.ex_reg_we = 1'b1;
      bus.ex_mem_re = 1'b1; bus.mem_rd = 5'd0; bus.mem_reg_we = 1'b1;
      #1 chk_ctl("x0_no_hazard", C_RUN);
      tick();

      // Taken branch with ready operands.
      idle();
      bus.id_branch = 1'b1; bus.id_branch_taken = 1'b1; bus.id_rs1 = 5'd3; bus.id_use_rs1 = 1'b1;
      bus.id_use_rs2 = 1'b1; bus.ex_rd = 5'd9; bus.ex_reg_we = 1'b1;
      #1 chk_ctl("branch_commit", C_COMMIT);
      tick();
      chk("branch_flush_cnt", 64'(bus.flush_cnt), 64'd1);

      // ld x5 ; add x6,x5,x1 -- first cycle: load in EX.
      idle();
      bus.id_rs1 = 5'd5; bus.id_rs2 = 5'd1; bus.id_use_rs1 = 1'b1; bus.id_use_rs2 = 1'b1;
      bus.ex_rd = 5'd5; bus.ex_reg_we = 1'b1; bus.ex_mem_re = 1'b1; bus.id_branch_taken = 1'b1;
      #1 chk_ctl("load_use_ex", C_STALL);
      tick();
      chk("load_use_stall_cnt", 64'(bus.stall_cnt), 64'd1);

`ifdef PIPE_CTRL_FORWARD_EN
      idle();
      bus.id_rs1 = 5'd5; bus.id_rs2 = 5'd1; bus.id_use_rs1 = 1'b1; bus.id_use_rs2 = 1'b1;
      bus.mem_rd = 5'd5; bus.mem_reg_we = 1'b1; bus.mem_mem_re = 1'b1;
      #1 chk_ctl("load_use_mem_go", C_RUN);
      chk("mem_load_not_source", 64'(bus.id_fwd_a_sel), 64'd0);
      tick();
      idle();
      bus.wb_rd = 5'd5; bus.wb_reg_we = 1'b1;
      #1 chk("load_use_ex_fwd_a", 64'(bus.ex_fwd_a_sel), 64'd2);
      chk("load_use_ex_fwd_b", 64'(bus.ex_fwd_b_sel), 64'd0);
      chk("load_use_total_stall", 64'(bus.stall_cnt), 64'd1);
      tick();

      // add x5 ; sub x7,x5,x5
      idle();
      bus.id_rs1 = 5'd5; bus.id_rs2 = 5'd5; bus.id_use_rs1 = 1'b1; bus.id_use_rs2 = 1'b1;
      bus.ex_rd = 5'd5; bus.ex_reg_we = 1'b1;
      #1 chk_ctl("alu_alu_no_stall", C_RUN);
      tick();
      idle();
      bus.mem_rd = 5'd5; bus.mem_reg_we = 1'b1;
      #1 chk("alu_fwd_a_mem", 64'(bus.ex_fwd_a_sel), 64'd1);
      chk("alu_fwd_b_mem", 64'(bus.ex_fwd_b_sel), 64'd1);
      tick();

      // addi x3 ; beq x3,x0 taken
      idle();
      bus.id_branch = 1'b1; bus.id_branch_taken = 1'b1; bus.id_rs1 = 5'd3;
      bus.id_use_rs1 = 1'b1; bus.id_use_rs2 = 1'b1; bus.ex_rd = 5'd3; bus.ex_reg_we = 1'b1;
      #1 chk_ctl("branch_alu_bubble", C_STALL);
      tick();
      bus.ex_rd = 5'd0; bus.ex_reg_we = 1'b0; bus.mem_rd = 5'd3; bus.mem_reg_we = 1'b1;
      #1 chk_ctl("branch_alu_commit", C_COMMIT);
      chk("branch_id_fwd_a", 64'(bus.id_fwd_a_sel), 64'd1);
      tick();
      chk("branch_alu_flush_cnt", 64'(bus.flush_cnt), 64'd2);
      chk("branch_alu_stall_cnt", 64'(bus.stall_cnt), 64'd2);
`else
      // Without forwarding the add waits until the load has left WB.
      idle();
      bus.id_rs1 = 5'd5; bus.id_rs2 = 5'd1; bus.id_use_rs1 = 1'b1; bus.id_use_rs2 = 1'b1;
      bus.mem_rd = 5'd5; bus.mem_reg_we = 1'b1; bus.mem_mem_re = 1'b1;
      #1 chk_ctl("nofwd_load_mem", C_STALL);
      tick();
      bus.mem_rd = 5'd0; bus.mem_reg_we = 1'b0; bus.mem_mem_re = 1'b0;
      bus.wb_rd = 5'd5; bus.wb_reg_we = 1'b1;
      #1 chk_ctl("nofwd_load_wb", C_STALL);
      tick();
      bus.wb_rd = 5'd0; bus.wb_reg_we = 1'b0;
      #1 chk_ctl("nofwd_load_released", C_RUN);
      tick();
      chk("nofwd_load_stall_cnt", 64'(bus.stall_cnt), 64'd3);
      idle();
      bus.mem_rd = 5'd5; bus.mem_reg_we = 1'b1; bus.id_rs1 = 5'd6; bus.id_use_rs1 = 1'b1;
      #1 chk("nofwd_ex_sel_tied", 64'(bus.ex_fwd_a_sel), 64'd0);
      chk_ctl("nofwd_ex_stage_run", C_RUN);
      tick();

      // add x5 ; add x6,x5,x0 -- three stall cycles.
      idle();
      bus.id_rs1 = 5'd5; bus.id_use_rs1 = 1'b1; bus.id_use_rs2 = 1'b1;
      bus.ex_rd = 5'd5; bus.ex_reg_we = 1'b1;
      #1 chk_ctl("nofwd_alu_ex", C_STALL);
      tick();
      bus.ex_reg_we = 1'b0; bus.mem_rd = 5'd5; bus.mem_reg_we = 1'b1;
      #1 chk_ctl("nofwd_alu_mem", C_STALL);
      chk("nofwd_id_sel_tied", 64'(bus.id_fwd_a_sel), 64'd0);
      tick();
      bus.mem_reg_we = 1'b0; bus.wb_rd = 5'd5; bus.wb_reg_we = 1'b1;
      #1 chk_ctl("nofwd_alu_wb", C_STALL);
      tick();
      bus.wb_reg_we = 1'b0;
      #1 chk_ctl("nofwd_alu_released", C_RUN);
      tick();
      chk("nofwd_alu_stall_cnt", 64'(bus.stall_cnt), 64'd6);

      // Branch waits on an ALU result in MEM, then commits once clear.
      idle();
      bus.id_branch = 1'b1; bus.id_branch_taken = 1'b1; bus.id_rs1 = 5'd3;
      bus.id_use_rs1 = 1'b1; bus.mem_rd = 5'd3; bus.mem_reg_we = 1'b1;
      #1 chk_ctl("nofwd_branch_stall", C_STALL);
      tick();
      bus.mem_reg_we = 1'b0;
      #1 chk_ctl("nofwd_branch_commit", C_COMMIT);
      tick();
      chk("nofwd_branch_flush_cnt", 64'(bus.flush_cnt), 64'd2);
      chk("nofwd_branch_stall_cnt", 64'(bus.stall_cnt), 64'd7);
`endif

      // sd with dmem_ready low for 3 cycles, load-use and a taken branch pending in ID.
      do_reset();
      idle();
      bus.mem_mem_we = 1'b1; bus.dmem_ready = 1'b0;
      bus.id_branch_taken = 1'b1; bus.id_rs1 = 5'd5; bus.id_use_rs1 = 1'b1;
      bus.ex_rd = 5'd5; bus.ex_reg_we = 1'b1; bus.ex_mem_re = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 chk_ctl("freeze_wait", C_FREEZE);
         tick();
      end
      chk("freeze_stall_cnt", 64'(bus.stall_cnt), 64'd3);
      bus.dmem_ready = 1'b1;
      #1 chk_ctl("freeze_release_bubble", C_STALL);
      tick();
      idle();
      #1 chk_ctl("after_freeze_run", C_RUN);
      chk("after_freeze_stall_cnt", 64'(bus.stall_cnt), 64'd4);

      // Timeout: 63 not-ready cycles are tolerated, the 64th raises mem_err.
      bus.mem_mem_re = 1'b1; bus.dmem_ready = 1'b0;
      for (int i = 0; i < 63; i++) tick();
      chk("timeout_63_no_err", 64'(bus.mem_err), 64'd0);
      tick();
      chk("timeout_64_err", 64'(bus.mem_err), 64'd1);
      idle();
      #1 chk_ctl("err_state_frozen", C_FREEZE);
      tick();
      chk("err_stall_cnt", 64'(bus.stall_cnt), 64'd69);
      chk("err_sticky", 64'(bus.mem_err), 64'd1);

      // Asynchronous reset mid-cycle clears everything at once.
      #3 rst = 1'b1;
      #1 chk_ctl("async_rst_ctl", C_ZERO);
      chk("async_rst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
      chk("async_rst_mem_err", 64'(bus.mem_err), 64'd0);
      #1 rst = 1'b0;
      tick();
      #1 chk_ctl("after_err_reset_run", C_RUN);
      tick();

      // Reset while in MEM_WAIT returns to RUN with no pending completion.
      bus.mem_mem_re = 1'b1; bus.dmem_ready = 1'b0;
      tick();
      tick();
      #3 rst = 1'b1;
      #1 chk_ctl("rst_mid_wait_ctl", C_ZERO);
      #1 rst = 1'b0;
      bus.dmem_ready = 1'b1;
      #1 chk_ctl("rst_mid_wait_run", C_RUN);
      tick();
      chk("rst_mid_wait_stall_cnt", 64'(bus.stall_cnt), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
